// File: rtl/coef_dequantizer.sv
`default_nettype none
// ============================================================================
//  Module      : coef_dequantizer
//  Description : Streaming JPEG coefficient dequantizer. Accepts signed
//                quantized DCT coefficients in zigzag order, multiplies each
//                by its quantization-table entry and emits a 32-bit
//                sign-magnitude fixed-point word (bit 31 sign, bits 30:0
//                magnitude with FRAC_BITS fractional bits).
//  Optional    : `define DEQUANT_DC_PRED_EN treats the index-0 coefficient as
//                a DC difference added to a running predictor.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                qt_wr_en/addr/data    - quant-table write port
//                in_valid/ready/coef/last - coefficient input stream
//                dc_pred_clr           - clears DC predictor (optional feature)
//                out_valid/ready/data/index/last - result stream
//                sat_flag, sync_err    - sticky status flags
//  Revision    : 1.0 - initial release
// ============================================================================
module coef_dequantizer #(
   parameter int COEF_W    = 12,
   parameter int Q_W       = 8,
   parameter int FRAC_BITS = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              qt_wr_en,
   input  logic [5:0]        qt_wr_addr,
   input  logic [Q_W-1:0]    qt_wr_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [COEF_W-1:0] in_coef,
   input  logic              in_last,
   input  logic              dc_pred_clr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic [5:0]        out_index,
   output logic              out_last,
   output logic              sat_flag,
   output logic              sync_err
);

   localparam int c_prod_w = COEF_W + Q_W;
   // Room for the full shifted product plus headroom so the saturation test
   // is a simple OR of every bit at or above bit 31.
   localparam int c_wide_w = c_prod_w + FRAC_BITS + 32;

   logic [Q_W-1:0]           r_qt [0:63];
   logic [5:0]               r_idx;

   logic                     r_s1_valid;
   logic [COEF_W-1:0]        r_s1_mag;
   logic                     r_s1_sign;
   logic                     r_s1_dsat;
   logic [Q_W-1:0]           r_s1_q;
   logic [5:0]               r_s1_idx;

   logic                     r_out_valid;
   logic [31:0]              r_out_data;
   logic [5:0]               r_out_index;
   logic                     r_out_last;
   logic                     r_sat;
   logic                     r_sync_err;

   logic                     w_adv;
   logic                     w_xfer;
   logic signed [COEF_W-1:0] w_coef_eff;
   logic                     w_dsat;
   logic [COEF_W-1:0]        w_abs;
   logic [c_prod_w-1:0]      w_prod;
   logic [c_wide_w-1:0]      w_wide;
   logic                     w_sat;
   logic [30:0]              w_mag;
   logic                     w_sign;

   // Both stages move together whenever the output register is free.
   assign w_adv    = !r_out_valid || out_ready;
   assign in_ready = w_adv;
   assign w_xfer   = in_valid && w_adv;

   // Quant table: no reset. The read below is combinational from the
   // current contents, so a same-edge write is seen only by later inputs.
   always_ff @(posedge clk) begin
      if (qt_wr_en) begin
         r_qt[qt_wr_addr] <= qt_wr_data;
      end
   end

`ifdef DEQUANT_DC_PRED_EN
   localparam logic signed [COEF_W:0] c_dc_max = {2'b00, {(COEF_W-1){1'b1}}};
   localparam logic signed [COEF_W:0] c_dc_min = {2'b11, {(COEF_W-1){1'b0}}};

   logic signed [COEF_W-1:0] r_pred;
   logic signed [COEF_W-1:0] w_pred_base;
   logic signed [COEF_W:0]   w_dc_sum;

   always_comb begin
      // A clear coinciding with an index-0 transfer takes effect first.
      w_pred_base = dc_pred_clr ? '0 : r_pred;
      w_dc_sum    = {w_pred_base[COEF_W-1], w_pred_base} + {in_coef[COEF_W-1], in_coef};
      w_coef_eff  = in_coef;
      w_dsat      = 1'b0;
      if (r_idx == 6'd0) begin
         if (w_dc_sum > c_dc_max) begin
            w_coef_eff = c_dc_max[COEF_W-1:0];
            w_dsat     = 1'b1;
         end else if (w_dc_sum < c_dc_min) begin
            w_coef_eff = c_dc_min[COEF_W-1:0];
            w_dsat     = 1'b1;
         end else begin
            w_coef_eff = w_dc_sum[COEF_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pred <= '0;
      end else if (w_xfer && (r_idx == 6'd0)) begin
         r_pred <= w_coef_eff;
      end else if (dc_pred_clr) begin
         r_pred <= '0;
      end
   end
`else
   logic w_unused_dc_clr;
   assign w_unused_dc_clr = dc_pred_clr;
   assign w_coef_eff      = in_coef;
   assign w_dsat          = 1'b0;
`endif

   // |x| as unsigned: the most negative value maps to 2^(COEF_W-1).
   assign w_abs = w_coef_eff[COEF_W-1] ? $unsigned(-w_coef_eff) : $unsigned(w_coef_eff);

   // Stage 1: magnitude, sign, table entry and index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_mag   <= '0;
         r_s1_sign  <= 1'b0;
         r_s1_dsat  <= 1'b0;
         r_s1_q     <= '0;
         r_s1_idx   <= '0;
      end else if (w_adv) begin
         r_s1_valid <= w_xfer;
         if (w_xfer) begin
            r_s1_mag  <= w_abs;
            r_s1_sign <= w_coef_eff[COEF_W-1];
            r_s1_dsat <= w_dsat;
            r_s1_q    <= r_qt[r_idx];
            r_s1_idx  <= r_idx;
         end
      end
   end

   // Index counter and block-sync check.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx      <= '0;
         r_sync_err <= 1'b0;
      end else if (w_xfer) begin
         r_idx <= in_last ? 6'd0 : r_idx + 6'd1;
         if (in_last != (r_idx == 6'd63)) begin
            r_sync_err <= 1'b1;
         end
      end
   end

   assign w_prod = {{Q_W{1'b0}}, r_s1_mag} * {{COEF_W{1'b0}}, r_s1_q};
   assign w_wide = {{(c_wide_w-c_prod_w){1'b0}}, w_prod} << FRAC_BITS;
   assign w_sat  = |w_wide[c_wide_w-1:31];
   assign w_mag  = w_sat ? {31{1'b1}} : w_wide[30:0];
   // A zero product is always reported as positive zero.
   assign w_sign = r_s1_sign && (w_prod != '0);

   // Stage 2: shifted and saturated sign-magnitude result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_index <= '0;
         r_out_last  <= 1'b0;
         r_sat       <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_data  <= {w_sign, w_mag};
            r_out_index <= r_s1_idx;
            r_out_last  <= (r_s1_idx == 6'd63);
            if (w_sat || r_s1_dsat) begin
               r_sat <= 1'b1;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_index = r_out_index;
   assign out_last  = r_out_last;
   assign sat_flag  = r_sat;
   assign sync_err  = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_coef_dequantizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coef_dequantizer
//  Description : Scoreboard bench for coef_dequantizer. Two instances share
//                one stimulus stream: the default build (FRAC_BITS=11) and a
//                FRAC_BITS=13 build that can reach magnitude saturation.
//                Expected words come from a plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coef_dequantizer;

   logic        clk;
   logic        rst_n;
   logic        qt_wr_en;
   logic [5:0]  qt_wr_addr;
   logic [7:0]  qt_wr_data;
   logic        in_valid;
   logic [11:0] in_coef;
   logic        in_last;
   logic        dc_pred_clr;
   logic        out_ready;

   logic        in_ready11, in_ready13;
   logic        o11_valid, o13_valid;
   logic [31:0] o11_data, o13_data;
   logic [5:0]  o11_index, o13_index;
   logic        o11_last, o13_last;
   logic        o11_sat, o13_sat;
   logic        o11_sync, o13_sync;

   coef_dequantizer #(.COEF_W(12), .Q_W(8), .FRAC_BITS(11)) dut (
      .clk(clk), .rst_n(rst_n),
      .qt_wr_en(qt_wr_en), .qt_wr_addr(qt_wr_addr), .qt_wr_data(qt_wr_data),
      .in_valid(in_valid), .in_ready(in_ready11), .in_coef(in_coef), .in_last(in_last),
      .dc_pred_clr(dc_pred_clr),
      .out_valid(o11_valid), .out_ready(out_ready), .out_data(o11_data),
      .out_index(o11_index), .out_last(o11_last),
      .sat_flag(o11_sat), .sync_err(o11_sync)
   );

   coef_dequantizer #(.COEF_W(12), .Q_W(8), .FRAC_BITS(13)) dut13 (
      .clk(clk), .rst_n(rst_n),
      .qt_wr_en(qt_wr_en), .qt_wr_addr(qt_wr_addr), .qt_wr_data(qt_wr_data),
      .in_valid(in_valid), .in_ready(in_ready13), .in_coef(in_coef), .in_last(in_last),
      .dc_pred_clr(dc_pred_clr),
      .out_valid(o13_valid), .out_ready(out_ready), .out_data(o13_data),
      .out_index(o13_index), .out_last(o13_last),
      .sat_flag(o13_sat), .sync_err(o13_sync)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] d11;
      logic [31:0] d13;
      int          idx;
      bit          sat11;
      bit          sat13;
   } exp_t;

   exp_t sbq[$];

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   int m_qt[64];
   int m_idx  = 0;
   bit m_sync = 0;
   int m_pred = 0;
   bit exp_sat11 = 0;
   bit exp_sat13 = 0;

   // monitor capture of the most recent accepted output
   logic [31:0] mon_d11, mon_d13;
   int          mon_idx;
   logic        mon_last;

   int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // {sat, sign, magnitude[30:0]} for coef * q scaled by 2^frac
   function automatic logic [32:0] ref_word(input int coef, input int q, input int frac);
      longint mag, sh;
      logic [32:0] r;
      mag   = longint'((coef < 0) ? -coef : coef) * longint'(q);
      sh    = mag * (longint'(1) << frac);
      r[32] = (sh > 64'sd2147483647);
      r[31] = (coef < 0) && (mag != 0);
      r[30:0] = r[32] ? 31'h7FFF_FFFF : sh[30:0];
      return r;
   endfunction

   task automatic model_accept(input int coef, input bit last);
      int eff;
      bit dsat;
      logic [32:0] r11, r13;
      exp_t e;
      eff  = coef;
      dsat = 1'b0;
`ifdef DEQUANT_DC_PRED_EN
      if (m_idx == 0) begin
         eff = m_pred + coef;
         if (eff > 2047)  begin eff = 2047;  dsat = 1'b1; end
         if (eff < -2048) begin eff = -2048; dsat = 1'b1; end
         m_pred = eff;
      end
`endif
      r11 = ref_word(eff, m_qt[m_idx], 11);
      r13 = ref_word(eff, m_qt[m_idx], 13);
      e.d11   = r11[31:0];
      e.d13   = r13[31:0];
      e.idx   = m_idx;
      e.sat11 = r11[32] | dsat;
      e.sat13 = r13[32] | dsat;
      sbq.push_back(e);
      if (last != (m_idx == 63)) m_sync = 1'b1;
      m_idx = last ? 0 : (m_idx + 1) % 64;
   endtask

   task automatic wr_qt(input int a, input int d);
      @(negedge clk);
      qt_wr_en   = 1'b1;
      qt_wr_addr = a[5:0];
      qt_wr_data = d[7:0];
      m_qt[a]    = d;
      @(posedge clk); #1;
      qt_wr_en   = 1'b0;
   endtask

   task automatic send(input int coef, input bit last,
                       input bit we = 1'b0, input int wa = 0, input int wd = 0);
      bit done;
      done       = 1'b0;
      in_valid   = 1'b1;
      in_coef    = coef[11:0];
      in_last    = last;
      qt_wr_en   = we;
      qt_wr_addr = wa[5:0];
      qt_wr_data = wd[7:0];
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (in_ready11) begin
            model_accept(coef, last);   // reads the table before this edge's write
            done = 1'b1;
         end
         if (we) m_qt[wa] = wd;
         @(posedge clk); #1;
         if (done) chk("sync_err_after_xfer", {o13_sync, o11_sync}, {m_sync, m_sync});
      end
      if (!done) begin
         n_chk++; n_fail++;
         $display("FAIL send_timeout: in_ready never rose, got 0 expected 1");
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      qt_wr_en = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 1000 && sbq.size() != 0; c++) @(posedge clk);
      chk("drain_queue_empty", sbq.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_state();
      chk("rst_valid", {o13_valid, o11_valid}, 2'b00);
      chk("rst_data11", o11_data, 32'h0);
      chk("rst_data13", o13_data, 32'h0);
      chk("rst_index", {o13_index, o11_index}, 12'h0);
      chk("rst_last", {o13_last, o11_last}, 2'b00);
      chk("rst_flags", {o13_sat, o11_sat, o13_sync, o11_sync}, 4'b0000);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      qt_wr_en = 1'b0;
      rst_n    = 1'b0;
      #2;
      check_reset_state();
      sbq.delete();
      m_idx = 0; m_sync = 1'b0; m_pred = 0;
      exp_sat11 = 1'b0; exp_sat13 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // monitor: pops the scoreboard on every output transfer
   bit          prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic [5:0]  prev_idx;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_data", o11_data, prev_data);
            chk("hold_index", o11_index, prev_idx);
         end
         if (o11_valid && !out_ready) chk("stall_in_ready", in_ready11, 1'b0);
         if (o11_valid || o13_valid) chk("valid_lockstep", o13_valid, o11_valid);
         if (o11_valid && out_ready) begin
            if (sbq.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_output: got index %0d data %h expected no output", o11_index, o11_data);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               exp_sat11 |= e.sat11;
               exp_sat13 |= e.sat13;
               chk("out_data11", o11_data, e.d11);
               chk("out_data13", o13_data, e.d13);
               chk("out_index", o11_index, e.idx);
               chk("out_last", {o13_last, o11_last}, {2{e.idx == 63}});
               chk("sat_flag", {o13_sat, o11_sat}, {exp_sat13, exp_sat11});
               mon_d11  = o11_data;
               mon_d13  = o13_data;
               mon_idx  = o11_index;
               mon_last = o11_last;
            end
         end
         prev_stall = o11_valid && !out_ready;
         prev_data  = o11_data;
         prev_idx   = o11_index;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int c;
      logic [11:0] rv;
      rst_n = 1'b0; qt_wr_en = 1'b0; qt_wr_addr = '0; qt_wr_data = '0;
      in_valid = 1'b0; in_coef = '0; in_last = 1'b0; dc_pred_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state();
      rst_n = 1'b1;

      // zero and negative values
      for (int i = 0; i < 64; i++) wr_qt(i, 1);
      wr_qt(0, 16);
      wr_qt(1, 99);
      send(-3, 1'b0);
      drain();
      chk("neg_coef_word", mon_d11, 32'h8001_8000);
      chk("neg_coef_index", mon_idx, 0);
      send(0, 1'b0);
      drain();
      chk("zero_coef_word", mon_d11, 32'h0);
      for (int i = 2; i < 64; i++) send(1, i == 63);
      drain();

      // full block of +1 with unit table
      wr_qt(0, 1);
      wr_qt(1, 1);
      for (int i = 0; i < 64; i++) send(1, i == 63);
      drain();
      chk("full_block_last_word", mon_d11, 32'h0000_0800);
      chk("full_block_last_flag", {mon_idx, mon_last}, {32'd63, 1'b1});
      chk("full_block_sync", o11_sync, 1'b0);

      // saturation (reachable only with FRAC_BITS=13)
      wr_qt(5, 255);
      for (int i = 0; i < 6; i++) send((i == 5) ? -2048 : 1, 1'b0);
      drain();
      chk("sat_word13", mon_d13, 32'hFFFF_FFFF);
      chk("sat_flag13", o13_sat, 1'b1);
`ifndef DEQUANT_DC_PRED_EN
      chk("nosat_word11", mon_d11, 32'hBFC0_0000);
      chk("nosat_flag11", o11_sat, 1'b0);
`endif
      for (int i = 6; i < 64; i++) send(1, i == 63);
      drain();
      chk("sat_flag13_sticky", o13_sat, 1'b1);

      // random blocks with random backpressure and concurrent table writes
      rdy_mode = 1;
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 64; i++) begin
            rv = 12'($urandom);
            c  = int'($signed(rv));
            if ($urandom_range(0, 3) == 0)
               send(c, i == 63, 1'b1, ($urandom_range(0, 1) == 0) ? m_idx : int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 255)));
            else
               send(c, i == 63);
         end
      end
      drain();

      // backpressure: out_ready held low for five cycles mid-stream
      rdy_mode = 0;
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               rv = 12'($urandom);
               send(int'($signed(rv)), 1'b0);
            end
         end
         begin
            repeat (6) @(posedge clk);
            rdy_mode = 2;
            repeat (5) @(posedge clk);
            rdy_mode = 0;
         end
      join
      drain();

      // write timing and sync error
      do_reset();
      wr_qt(0, 1);
      send(4, 1'b0, 1'b1, 0, 50);
      drain();
      chk("same_cycle_write_old", mon_d11, 32'h0000_2000);
      send(1, 1'b0);
      send(7, 1'b1);
      chk("sync_err_early_last", {o13_sync, o11_sync}, 2'b11);
      send(1, 1'b0);
      drain();
      chk("index_after_last", mon_idx, 0);
`ifndef DEQUANT_DC_PRED_EN
      chk("later_write_new", mon_d11, 32'h0001_9000);
`endif

      // reset in the middle of a block, in-flight results discarded
      rdy_mode = 1;
      for (int i = 0; i < 20; i++) begin
         rv = 12'($urandom);
         send(int'($signed(rv)), 1'b0);
      end
      do_reset();
      rdy_mode = 0;
      wr_qt(0, 1);
      send(5, 1'b1);
      drain();
      chk("post_reset_index", mon_idx, 0);
      chk("post_reset_word", mon_d11, 32'h0000_2800);
      send(-2, 1'b1);
      drain();
`ifdef DEQUANT_DC_PRED_EN
      chk("dc_pred_word", mon_d11, 32'h0000_1800);
`else
      chk("dc_direct_word", mon_d11, 32'h8000_1000);
`endif

      repeat (4) @(posedge clk);
      chk("final_queue_empty", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/coef_dequantizer.md
Name: coef_dequantizer

Overview:
- Streaming dequantizer for the JPEG decode path.
- Takes signed quantized DCT coefficients in zigzag order, one 8x8 block at a time, and multiplies each by its quantization-table entry.
- Emits each result as a 32-bit sign-magnitude fixed-point word: bit 31 is the sign, bits 30:0 are the magnitude with FRAC_BITS fractional bits. This is the format the downstream rounding stage consumes.
- Sits between the entropy decoder and the IDCT/rounding datapath.

Parameters:
COEF_W, 12, width of signed two's-complement input coefficient
Q_W, 8, width of unsigned quantization-table entry
FRAC_BITS, 11, number of fractional bits in output magnitude field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
qt_wr_en  in  1  quant-table write strobe
qt_wr_addr  in  6  zigzag index of table entry to write
qt_wr_data  in  Q_W  table entry value
in_valid  in  1  coefficient valid
in_ready  out  1  block can accept coefficient
in_coef  in  COEF_W  signed quantized coefficient
in_last  in  1  marks last coefficient of block
dc_pred_clr  in  1  clears DC predictor (used only with optional feature)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  32  sign-magnitude fixed-point result
out_index  out  6  zigzag index of out_data
out_last  out  1  out_index == 63
sat_flag  out  1  sticky: a magnitude saturated
sync_err  out  1  sticky: in_last disagreed with index counter

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_data=0, out_index=0, out_last=0, sat_flag=0, sync_err=0, index counter=0, DC predictor=0. The quant table is not reset.
- Handshake: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready. out_data/out_index/out_last hold stable while out_valid&&!out_ready.
- Pipeline has two stages, advanced by adv = !out_valid || out_ready. in_ready = adv, combinational from out_ready and out_valid.
- Stage 1 registers: |coef|, sign, the table entry read at the current index, and the index.
- Stage 2 registers: the product, left shifted by FRAC_BITS, plus the sign.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle.
- Bubbles: a stage-1 bubble (no input transfer) propagates as out_valid=0 when stage 2 advances.
- Index counter: increments on each input transfer and wraps 63->0.
- in_last handling:
  - in_last on a transfer forces the counter to 0 for the next coefficient.
  - If in_last is at index != 63, or index 63 arrives without in_last, set sync_err. It is sticky until reset.
- Arithmetic:
  - mag = |in_coef| * qt[index], at most 2^(COEF_W-1) * (2^Q_W - 1).
  - shifted = mag << FRAC_BITS, computed at full width.
  - If shifted > 2^31-1, the magnitude becomes 0x7FFFFFFF and sat_flag is set (sticky).
  - Sign = in_coef<0. A zero result always has sign 0 (no negative zero).
- Table writes:
  - A qt_wr_en write lands on the clock edge.
  - A coefficient accepted in the same cycle, at the same address, reads the old value.
  - Coefficients accepted in later cycles read the new value.
  - Writes are allowed at any time, including during stalls.
- Reset asserted mid-block: everything listed above clears immediately, and in-flight results are discarded.

Optional Feature:
- Macro: DEQUANT_DC_PRED_EN.
- When defined, the coefficient at index 0 is treated as a DC difference:
  - coef_eff = pred + in_coef, saturated to the signed COEF_W range; saturation sets sat_flag.
  - pred is updated to coef_eff on that transfer.
  - dc_pred_clr=1 zeroes pred on the next edge. If it coincides with an index-0 transfer, it is applied before the add, giving coef_eff = in_coef.
- When not defined, in_coef is used directly and dc_pred_clr is ignored.

Test Plan:
- Zero and negative values: qt[0]=16, coef -3 at index 0 -> out_data=0x80018000, out_index=0 two cycles later. Coef 0 with qt=99 -> out_data=0x00000000.
- Full block: qt[i]=1 for all i, 64 coefs of +1 with in_last on the 64th -> 64 outputs of 0x00000800, out_last only on index 63, sync_err=0.
- Saturation: FRAC_BITS=13, qt[5]=255, coef -2048 at index 5 -> out_data=0xFFFFFFFF, sat_flag=1 and stays 1.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 after pipeline fills, out_data held constant, no loss or duplication when ready returns.
- Sync error and write timing:
  - in_last at index 10 -> sync_err=1, next coef gets index 0.
  - A qt write to addr 0 in the same cycle as the index-0 transfer -> old value used.
- Reset mid-block: pulse rst_n low after 20 coefs -> all outputs 0, next accepted coef reports index 0.
- With DEQUANT_DC_PRED_EN: DC diffs +5 then -2 with qt[0]=1 -> 0x00002800 then 0x00001800.
